// File: rtl/ifetch_ctrl_if.sv
// Bundle of cache-side and consumer-side signals of the instruction fetch controller.
// master is the fetch controller; slave is the cache/decoder environment.
interface ifetch_ctrl_if #(
    parameter int QDEPTH = 16
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [31:0]      Ic_pc;
    logic             Ic_rd_en;
    logic [127:0]     Ic_dout;
    logic             Ic_dout_valid;
    logic             Branch_valid;
    logic [31:0]      Branch_addr;
    logic             Deq_en;
    logic [31:0]      Instr;
    logic [31:0]      Instr_pc;
    logic             Instr_valid;
    logic [CNT_W-1:0] Q_count;

    modport master (
        output Ic_pc, Ic_rd_en, Instr, Instr_pc, Instr_valid, Q_count,
        input  Ic_dout, Ic_dout_valid, Branch_valid, Branch_addr, Deq_en
    );

    modport slave (
        input  Ic_pc, Ic_rd_en, Instr, Instr_pc, Instr_valid, Q_count,
        output Ic_dout, Ic_dout_valid, Branch_valid, Branch_addr, Deq_en
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: requests 16-byte cache lines, enqueues the words into a
// circular {pc, instr} queue and handles branch redirects with a one-cycle bubble.
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 16
) (
    input  logic          clk,
    input  logic          reset,
    ifetch_ctrl_if.master bus
);
    localparam int PTR_W = $clog2(QDEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        REDIR = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [31:0]      fetch_pc_reg, fetch_pc_next;
    logic [1:0]       skip_reg, skip_next;
    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [31:0]      instr_reg, instr_next;
    logic [31:0]      instr_pc_reg, instr_pc_next;

    logic [31:0] mem_instr [QDEPTH];
    logic [31:0] mem_pc    [QDEPTH];

    logic             rd_en;
    logic             accept;
    logic             pop;
    logic             flush;
    logic [2:0]       n_acc;
    logic [3:0]       lane_mask;
    logic [3:0]       lane_we;
    logic [CNT_W-1:0] free_now;
    logic [CNT_W-1:0] free_next;

    logic [PTR_W-1:0] lane_addr  [4];
    logic [31:0]      lane_instr [4];
    logic [31:0]      lane_pc    [4];

    // Low address bits only select the first word via skip; keep them visibly consumed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.Branch_addr[1:0];

    // Lane gi carries the word at line offset gi; it lands (gi - skip) slots past the tail.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi]  = tail_reg + PTR_W'(2'(gi) - skip_reg);
            assign lane_instr[gi] = bus.Ic_dout[127-32*gi -: 32];
            assign lane_pc[gi]    = fetch_pc_reg + 32'(4 * gi);
        end
    endgenerate

    always_comb begin
        free_now = CNT_W'(QDEPTH) - count_reg;
        rd_en    = (state_reg == RUN) && !reset && (free_now >= CNT_W'(4));
        flush    = bus.Branch_valid;
        accept   = rd_en && bus.Ic_dout_valid && !bus.Branch_valid;
        pop      = bus.Deq_en && (count_reg != '0) && !bus.Branch_valid;

        lane_mask = 4'b1111;
        n_acc     = 3'd4;
        case (skip_reg)
            2'd1:    begin lane_mask = 4'b1110; n_acc = 3'd3; end
            2'd2:    begin lane_mask = 4'b1100; n_acc = 3'd2; end
            2'd3:    begin lane_mask = 4'b1000; n_acc = 3'd1; end
            default: begin lane_mask = 4'b1111; n_acc = 3'd4; end
        endcase
        lane_we = accept ? lane_mask : 4'b0000;
        if (!accept) begin
            n_acc = 3'd0;
        end

        if (flush) begin
            count_next    = '0;
            head_next     = '0;
            tail_next     = '0;
            fetch_pc_next = {bus.Branch_addr[31:4], 4'b0000};
            skip_next     = bus.Branch_addr[3:2];
        end else begin
            count_next    = count_reg + CNT_W'(n_acc) - CNT_W'(pop);
            head_next     = head_reg + PTR_W'(pop);
            tail_next     = tail_reg + PTR_W'(n_acc);
            fetch_pc_next = accept ? fetch_pc_reg + 32'd16 : fetch_pc_reg;
            skip_next     = accept ? 2'd0 : skip_reg;
        end
        free_next = CNT_W'(QDEPTH) - count_next;

        // Head output is registered, so forward a word being written into the new head slot.
        instr_next    = mem_instr[head_next];
        instr_pc_next = mem_pc[head_next];
        for (int l = 0; l < 4; l++) begin
            if (lane_we[l] && (lane_addr[l] == head_next)) begin
                instr_next    = lane_instr[l];
                instr_pc_next = lane_pc[l];
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (bus.Branch_valid) begin
            state_next = REDIR;
        end else begin
            case (state_reg)
                RUN, HOLD: state_next = (free_next >= CNT_W'(4)) ? RUN : HOLD;
                REDIR:     state_next = RUN;
                default:   state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            fetch_pc_reg <= RESET_PC;
            skip_reg     <= 2'd0;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            skip_reg     <= skip_next;
            head_reg     <= head_next;
            tail_reg     <= tail_next;
            count_reg    <= count_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (lane_we[l]) begin
                mem_instr[lane_addr[l]] <= lane_instr[l];
                mem_pc[lane_addr[l]]    <= lane_pc[l];
            end
        end
    end

    assign bus.Ic_pc       = fetch_pc_reg;
    assign bus.Ic_rd_en    = rd_en;
    assign bus.Instr       = instr_reg;
    assign bus.Instr_pc    = instr_pc_reg;
    assign bus.Instr_valid = (count_reg != '0);
    assign bus.Q_count     = count_reg;
endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: directed vector table, corner-case sequences and a
// random run, all backed by a reference model with an expected-instruction queue.
module tb_ifetch_ctrl;
    localparam int          QDEPTH   = 16;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          M_RUN    = 0;
    localparam int          M_HOLD   = 1;
    localparam int          M_REDIR  = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ifetch_ctrl_if #(.QDEPTH(QDEPTH)) bus ();

    ifetch_ctrl #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Zero-latency cache: the line for whatever address is presented.
    assign bus.Ic_dout = {mem_word(bus.Ic_pc), mem_word(bus.Ic_pc + 32'd4),
                          mem_word(bus.Ic_pc + 32'd8), mem_word(bus.Ic_pc + 32'd12)};

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        dv;
        logic        br;
        logic [31:0] ba;
        logic        dq;
        logic        e_rd;
        logic [31:0] e_pc;
        int          e_q;
        logic        e_vld;
        logic [31:0] e_ipc;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lines    = 0;
    int          m_state;
    logic [31:0] m_pc;
    logic [1:0]  m_skip;
    ent_t        sb[$];

    logic        obs_rd;
    logic        obs_vld;
    logic [31:0] obs_pc;
    logic [31:0] obs_ipc;
    logic [31:0] obs_instr;
    int          obs_q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, compare DUT against the model mid-cycle, then advance the model.
    task automatic step(input logic rst, input logic dv, input logic br,
                        input logic [31:0] ba, input logic dq);
        logic m_rd;
        ent_t e;
        reset             = rst;
        bus.Ic_dout_valid = dv;
        bus.Branch_valid  = br;
        bus.Branch_addr   = ba;
        bus.Deq_en        = dq;
        @(negedge clk);
        m_rd = !rst && (m_state == M_RUN) && ((QDEPTH - sb.size()) >= 4);
        obs_rd    = bus.Ic_rd_en;
        obs_pc    = bus.Ic_pc;
        obs_q     = int'(bus.Q_count);
        obs_vld   = bus.Instr_valid;
        obs_ipc   = bus.Instr_pc;
        obs_instr = bus.Instr;
        check("ic_rd_en", 32'(obs_rd), 32'(m_rd));
        check("ic_pc", obs_pc, m_pc);
        check("q_count", 32'(obs_q), 32'(sb.size()));
        check("instr_valid", 32'(obs_vld), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            check("instr_pc", obs_ipc, sb[0].pc);
            check("instr", obs_instr, sb[0].instr);
        end
        if (rst) begin
            m_state = M_RUN;
            m_pc    = RESET_PC;
            m_skip  = 2'd0;
            sb.delete();
        end else if (br) begin
            sb.delete();
            m_pc    = {ba[31:4], 4'b0000};
            m_skip  = ba[3:2];
            m_state = M_REDIR;
        end else begin
            if (dq && sb.size() != 0) begin
                void'(sb.pop_front());
            end
            if (m_rd && dv) begin
                for (int o = int'(m_skip); o < 4; o++) begin
                    e.pc    = m_pc + 32'(4 * o);
                    e.instr = mem_word(e.pc);
                    sb.push_back(e);
                end
                $display("line %0d accepted: ic_pc=%08h words=%0d q=%0d",
                         lines, m_pc, 4 - int'(m_skip), sb.size());
                lines++;
                m_pc   = m_pc + 32'd16;
                m_skip = 2'd0;
            end
            if (m_state == M_REDIR) m_state = M_RUN;
            else m_state = ((QDEPTH - sb.size()) >= 4) ? M_RUN : M_HOLD;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic rst, input logic dv, input logic br,
                                input logic [31:0] ba, input logic dq, input logic e_rd,
                                input logic [31:0] e_pc, input int e_q, input logic e_vld,
                                input logic [31:0] e_ipc);
        vec_t v;
        v.rst = rst; v.dv = dv; v.br = br; v.ba = ba; v.dq = dq;
        v.e_rd = e_rd; v.e_pc = e_pc; v.e_q = e_q; v.e_vld = e_vld; v.e_ipc = e_ipc;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        int acc_cnt;
        int cyc;
        logic rd_at_third;

        // rst dv br ba dq | rd pc q vld instr_pc (outputs seen during that cycle)
        tbl[0]  = mk(1, 1, 1, 32'h500, 0, 0, 32'h000, 0,  0, 32'h0);
        tbl[1]  = mk(1, 1, 0, 32'h0,   0, 0, 32'h000, 0,  0, 32'h0);
        tbl[2]  = mk(0, 1, 0, 32'h0,   0, 1, 32'h000, 0,  0, 32'h0);
        tbl[3]  = mk(0, 1, 0, 32'h0,   1, 1, 32'h010, 4,  1, 32'h0);
        tbl[4]  = mk(0, 1, 0, 32'h0,   1, 1, 32'h020, 7,  1, 32'h4);
        tbl[5]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h030, 10, 1, 32'h8);
        tbl[6]  = mk(0, 1, 1, 32'h108, 1, 1, 32'h030, 9,  1, 32'hC);
        tbl[7]  = mk(0, 1, 0, 32'h0,   1, 0, 32'h100, 0,  0, 32'h0);
        tbl[8]  = mk(0, 1, 0, 32'h0,   0, 1, 32'h100, 0,  0, 32'h0);
        tbl[9]  = mk(0, 0, 0, 32'h0,   1, 1, 32'h110, 2,  1, 32'h108);
        tbl[10] = mk(0, 0, 0, 32'h0,   1, 1, 32'h110, 1,  1, 32'h10C);
        tbl[11] = mk(0, 0, 0, 32'h0,   1, 1, 32'h110, 0,  0, 32'h0);
        tbl[12] = mk(0, 0, 0, 32'h0,   0, 1, 32'h110, 0,  0, 32'h0);

        reset             = 1'b1;
        bus.Ic_dout_valid = 1'b0;
        bus.Branch_valid  = 1'b0;
        bus.Branch_addr   = 32'h0;
        bus.Deq_en        = 1'b0;
        m_state = M_RUN;
        m_pc    = RESET_PC;
        m_skip  = 2'd0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].dv, tbl[i].br, tbl[i].ba, tbl[i].dq);
            check($sformatf("vec%0d_rd_en", i), 32'(obs_rd), 32'(tbl[i].e_rd));
            check($sformatf("vec%0d_ic_pc", i), obs_pc, tbl[i].e_pc);
            check($sformatf("vec%0d_q_count", i), 32'(obs_q), 32'(tbl[i].e_q));
            check($sformatf("vec%0d_valid", i), 32'(obs_vld), 32'(tbl[i].e_vld));
            if (tbl[i].e_vld) begin
                check($sformatf("vec%0d_instr_pc", i), obs_ipc, tbl[i].e_ipc);
                check($sformatf("vec%0d_instr", i), obs_instr, mem_word(tbl[i].e_ipc));
            end
        end

        // Fill until the queue is full, then drain four entries to reopen fetching.
        step(1, 0, 0, 32'h0, 0);
        acc_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 32'h0, 0);
            if (obs_rd) acc_cnt++;
        end
        check("fill_lines", 32'(acc_cnt), 32'd4);
        check("fill_q_count", 32'(obs_q), 32'd16);
        check("fill_rd_en", 32'(obs_rd), 32'd0);
        rd_at_third = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 32'h0, 1);
            if (k == 3) rd_at_third = obs_rd;
        end
        check("hold_rd_en_q13", 32'(rd_at_third), 32'd0);
        step(0, 0, 0, 32'h0, 0);
        check("resume_q_count", 32'(obs_q), 32'd12);
        check("resume_rd_en", 32'(obs_rd), 32'd1);

        // Branch colliding with an accepted line and a dequeue.
        step(1, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 0, 0, 32'h0, 0);
        step(0, 1, 1, 32'h2004, 1);
        check("coll_rd_en_before", 32'(obs_rd), 32'd1);
        step(0, 1, 0, 32'h0, 1);
        check("coll_q_flushed", 32'(obs_q), 32'd0);
        check("coll_bubble_rd_en", 32'(obs_rd), 32'd0);
        check("coll_target_pc", obs_pc, 32'h2000);
        step(0, 1, 0, 32'h0, 0);
        check("coll_refetch_rd_en", 32'(obs_rd), 32'd1);
        check("coll_refetch_pc", obs_pc, 32'h2000);
        step(0, 0, 0, 32'h0, 0);
        check("coll_q_after", 32'(obs_q), 32'd3);
        check("coll_head_pc", obs_ipc, 32'h2004);

        // Fetch address wraps from the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFF0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        check("wrap_fetch_pc", obs_pc, 32'hFFFF_FFF0);
        step(0, 0, 0, 32'h0, 0);
        check("wrap_next_pc", obs_pc, 32'h0000_0000);
        for (int k = 0; k < 5; k++) step(0, 0, 0, 32'h0, 1);

        // Reset in the middle of a line transfer.
        step(0, 0, 1, 32'h3000, 0);
        step(0, 1, 0, 32'h0, 0);
        step(0, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 0);
        check("rst_mid_q_count", 32'(obs_q), 32'd0);
        check("rst_mid_pc", obs_pc, RESET_PC);
        check("rst_mid_rd_en", 32'(obs_rd), 32'd1);

        // Random traffic across many pointer wraps with occasional redirects.
        step(1, 0, 0, 32'h0, 0);
        lines = 0;
        cyc   = 0;
        while (lines < 110 && cyc < 5000) begin
            step(0, $urandom_range(0, 9) < 8, $urandom_range(0, 99) == 0,
                 $urandom & 32'hFFFF_FFFC, $urandom_range(0, 9) < 6);
            cyc++;
        end
        check("random_line_budget", 32'(lines >= 110), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
